pmem_arbiter_rr: RTL and testbench

//  N-port arbiter between cache-side requesters (I$, D$, optional prefetch or victim buffer)
//  and the single physical-memory port. One transaction at a time is in flight.

---
 rtl/pmem_arb_pkg.sv | 21 ++
 rtl/pmem_arbiter_rr_pick.sv | 37 +++
 rtl/pmem_arbiter_rr.sv | 135 +++++++++++++
 tb/tb_pmem_arbiter_rr.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// Shared types and helpers for the physical-memory port arbiter.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    RECOVER
  } arb_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_e;

  // Index width for a port count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from a pointer or fixed lowest-index priority.
module arb_pick
  import pmem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic [IDX_W-1:0]     win_idx,
  output logic                 win_valid
);

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [2*NUM_PORTS-1:0] req_rot;
  int unsigned            base;
  int unsigned            pos;

  // Doubling the vector lets a single forward scan from the pointer cover the wrap-around.
  always_comb begin
    req_dbl   = {req, req};
    base      = rr_mode ? 32'(ptr) : '0;
    req_rot   = req_dbl >> base;
    pos       = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_valid && req_rot[i]) begin
        win_valid = 1'b1;
        pos       = base + i;
        win_idx   = IDX_W'((pos >= NUM_PORTS) ? pos - NUM_PORTS : pos);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter_rr.sv
// N-port arbiter in front of a single physical-memory port; one transaction in flight,
// request latched at grant, registered read data returned with a one-cycle ready pulse.
module pmem_arbiter_rr
  import pmem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned RR_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        port_ready,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_addr,
  output logic [DATA_W-1:0]           pmem_wdata,
  input  logic [DATA_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);

  arb_state_e             state_q, state_d;
  arb_op_e                op_q, op_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   ready_q, ready_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;

  logic [NUM_PORTS-1:0]   req_any;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;

  assign req_any = req_read | req_write;

  arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req       (req_any),
    .ptr       (ptr_q),
    .rr_mode   (RR_MODE != 0),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          op_d    = req_write[win_idx] ? OP_WRITE : OP_READ;
          addr_d  = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
          wdata_d = req_wdata[32'(win_idx) * DATA_W +: DATA_W];
          rd_d    = !req_write[win_idx];
          wr_d    = req_write[win_idx];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          if (op_q == OP_READ) rdata_d = pmem_rdata;
          ready_d[grant_q] = 1'b1;
          state_d          = RESPOND;
        end else begin
          rd_d = (op_q == OP_READ);
          wr_d = (op_q == OP_WRITE);
        end
      end
      RESPOND: begin
        if (RR_MODE != 0) begin
          ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
        state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Address and write line are held internally but only presented while a strobe is up.
  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = (rd_q | wr_q) ? addr_q : '0;
  assign pmem_wdata = (rd_q | wr_q) ? wdata_q : '0;
  assign port_ready = ready_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Bench for pmem_arbiter_rr: a 3-port round-robin instance driven from a vector table with a
// ready/rdata scoreboard, and a 2-port fixed-priority instance for the priority hold case.
module tb_pmem_arbiter_rr;

  localparam int NA = 3;
  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0]    a_rd, a_wr, a_ready;
  logic [NA*AW-1:0] a_addr;
  logic [NA*DW-1:0] a_wdata;
  logic [DW-1:0]    a_rresp, a_pwdata, a_prdata;
  logic [AW-1:0]    a_paddr;
  logic             a_pr, a_pw, a_presp;

  logic [NB-1:0]    b_rd, b_wr, b_ready;
  logic [NB*AW-1:0] b_addr;
  logic [NB*DW-1:0] b_wdata;
  logic [DW-1:0]    b_rresp, b_pwdata, b_prdata;
  logic [AW-1:0]    b_paddr;
  logic             b_pr, b_pw, b_presp;

  pmem_arbiter_rr #(.NUM_PORTS(NA), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .port_ready(a_ready), .resp_rdata(a_rresp), .pmem_read(a_pr),
    .pmem_write(a_pw), .pmem_addr(a_paddr), .pmem_wdata(a_pwdata), .pmem_rdata(a_prdata),
    .pmem_resp(a_presp)
  );

  pmem_arbiter_rr #(.NUM_PORTS(NB), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .port_ready(b_ready), .resp_rdata(b_rresp), .pmem_read(b_pr),
    .pmem_write(b_pw), .pmem_addr(b_paddr), .pmem_wdata(b_pwdata), .pmem_rdata(b_prdata),
    .pmem_resp(b_presp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NA-1:0] ready;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_head;
  logic [DW-1:0] exp_rdata_a;

  typedef struct {
    logic [NA-1:0] rd;
    logic [NA-1:0] wr;
    logic [AW-1:0] base;
    int            delay;
    int            port;
    logic          wr_exp;
    logic          chg;
    int            exp_wait;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int p);
    return base + AW'(p * 32'h40);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input logic [AW-1:0] base, input int p);
    return {8{addr_of(base, p) ^ 32'hC0DE_0000}};
  endfunction

  // Scoreboard side: every ready pulse on A must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && a_ready != '0) begin
      if (sb_q.size() == 0) begin
        check("a_ready_unexpected", DW'(a_ready), '0);
      end else begin
        sb_head = sb_q.pop_front();
        check("a_sb_ready", DW'(a_ready), DW'(sb_head.ready));
        check("a_sb_rdata", a_rresp, sb_head.rdata);
      end
    end
  end

  task automatic drive_a(input logic [NA-1:0] rd, input logic [NA-1:0] wr, input logic [AW-1:0] base);
    a_rd = rd;
    a_wr = wr;
    for (int p = 0; p < NA; p++) begin
      a_addr[p*AW +: AW]  = addr_of(base, p);
      a_wdata[p*DW +: DW] = wdata_of(base, p);
    end
  endtask

  task automatic wait_strobe_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_pr | a_pw) && n < 20);
    if (!(a_pr | a_pw)) check("a_strobe_timeout", DW'(a_pr | a_pw), DW'(1));
  endtask

  task automatic run_a(input vec_t v, input int idx);
    int n;
    logic [DW-1:0] line;
    sb_t e;
    line = v.chg ? {32{8'hA5}} : {8{32'hA5A5_0000 + 32'(idx)}};
    drive_a(v.rd, v.wr, v.base);
    wait_strobe_a(n);
    if (v.exp_wait != 0) check("a_grant_latency", DW'(n), DW'(v.exp_wait));
    check("a_pmem_write", DW'(a_pw), DW'(v.wr_exp));
    check("a_pmem_read", DW'(a_pr), DW'(!v.wr_exp));
    check("a_pmem_addr", DW'(a_paddr), DW'(addr_of(v.base, v.port)));
    if (v.wr_exp) check("a_pmem_wdata", a_pwdata, wdata_of(v.base, v.port));
    if (!v.wr_exp) exp_rdata_a = line;
    e.ready = NA'(1) << v.port;
    e.rdata = exp_rdata_a;
    sb_q.push_back(e);
    if (v.chg) begin
      a_rd = '0;
      a_wr = '0;
      a_addr[v.port*AW +: AW] = addr_of(v.base, v.port) + 32'h100;
    end
    for (int c = 1; c < v.delay; c++) begin
      @(negedge clk);
      check("a_strobe_hold", DW'(a_pr | a_pw), DW'(1));
      check("a_addr_hold", DW'(a_paddr), DW'(addr_of(v.base, v.port)));
    end
    a_presp  = 1'b1;
    a_prdata = line;
    @(negedge clk);
    a_presp  = 1'b0;
    a_prdata = '0;
    check("a_strobe_drop", DW'(a_pr | a_pw), '0);
    check("a_ready_latency", DW'(a_ready), DW'(NA'(1) << v.port));
    a_rd = '0;
    a_wr = '0;
  endtask

  task automatic run_b(input int port, input logic [DW-1:0] line);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_pr && n < 20);
    check("b_pmem_read", DW'(b_pr), DW'(1));
    check("b_pmem_addr", DW'(b_paddr), DW'(addr_of(32'h500, port)));
    b_presp  = 1'b1;
    b_prdata = line;
    @(negedge clk);
    b_presp  = 1'b0;
    b_prdata = '0;
    check("b_ready", DW'(b_ready), DW'(NB'(1) << port));
    check("b_resp_rdata", b_rresp, line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //        rd      wr      base          dly port wr    chg  wait
    vecs[0]  = '{3'b000, 3'b010, 32'h0000_0000, 3, 1, 1'b1, 1'b0, 3};
    vecs[1]  = '{3'b111, 3'b000, 32'h0000_1000, 2, 2, 1'b0, 1'b0, 3};
    vecs[2]  = '{3'b111, 3'b000, 32'h0000_2000, 2, 0, 1'b0, 1'b0, 3};
    vecs[3]  = '{3'b111, 3'b000, 32'h0000_3000, 1, 1, 1'b0, 1'b0, 3};
    vecs[4]  = '{3'b111, 3'b000, 32'h0000_4000, 2, 2, 1'b0, 1'b0, 3};
    vecs[5]  = '{3'b111, 3'b000, 32'h0000_5000, 4, 0, 1'b0, 1'b0, 3};
    vecs[6]  = '{3'b001, 3'b000, 32'h0000_6000, 2, 0, 1'b0, 1'b0, 3};
    vecs[7]  = '{3'b001, 3'b001, 32'h0000_7000, 2, 0, 1'b1, 1'b0, 3};
    vecs[8]  = '{3'b100, 3'b010, 32'h0000_8000, 2, 1, 1'b1, 1'b0, 3};
    vecs[9]  = '{3'b011, 3'b000, 32'h0000_9000, 2, 0, 1'b0, 1'b0, 3};
    vecs[10] = '{3'b110, 3'b000, 32'h0000_A000, 1, 1, 1'b0, 1'b0, 3};
    vecs[11] = '{3'b001, 3'b000, 32'h0000_0100, 3, 0, 1'b0, 1'b1, 3};

    a_presp = 1'b0; a_prdata = '0;
    b_presp = 1'b0; b_prdata = '0;
    b_rd = '0; b_wr = '0;
    for (int p = 0; p < NB; p++) begin
      b_addr[p*AW +: AW]  = addr_of(32'h500, p);
      b_wdata[p*DW +: DW] = wdata_of(32'h500, p);
    end
    exp_rdata_a = '0;

    // Reset with requests held: everything stays quiet until release.
    drive_a(3'b011, 3'b000, 32'h0000_F000);
    b_rd = 2'b11;
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_a_strobes", DW'({a_pr, a_pw}), '0);
      check("rst_a_ready", DW'(a_ready), '0);
      check("rst_a_addr", DW'(a_paddr), '0);
      check("rst_a_rdata", a_rresp, '0);
      check("rst_b_outputs", DW'({b_pr, b_pw, b_ready}), '0);
    end
    b_rd = '0;
    rst  = 1'b0;
    run_a('{3'b011, 3'b000, 32'h0000_F000, 2, 0, 1'b0, 1'b0, 1}, 100);

    for (int i = 0; i < 12; i++) run_a(vecs[i], i);

    // Stray pmem_resp while idle must not produce a ready pulse or strobe.
    repeat (3) @(negedge clk);
    a_presp = 1'b1;
    @(negedge clk);
    a_presp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_resp_ready", DW'(a_ready), '0);
      check("idle_resp_strobe", DW'(a_pr | a_pw), '0);
    end

    // Reset two cycles into BUSY: strobes fall at once, no ready, pointer back to 0.
    drive_a(3'b010, 3'b000, 32'h0000_B000);
    wait_strobe_a(n);
    check("abort_grant_addr", DW'(a_paddr), DW'(addr_of(32'h0000_B000, 1)));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_strobes", DW'({a_pr, a_pw}), '0);
    check("abort_ready", DW'(a_ready), '0);
    check("abort_rdata", a_rresp, '0);
    exp_rdata_a = '0;
    @(negedge clk);
    check("abort_ready_hold", DW'(a_ready), '0);
    rst = 1'b0;
    run_a('{3'b011, 3'b000, 32'h0000_C000, 2, 0, 1'b0, 1'b0, 1}, 200);

    // Fixed priority: port 0 wins while it holds its request, then port 1.
    b_rd = 2'b11;
    run_b(0, {8{32'hB000_0001}});
    run_b(0, {8{32'hB000_0002}});
    run_b(0, {8{32'hB000_0003}});
    b_rd = 2'b10;
    run_b(1, {8{32'hB000_0004}});
    b_rd = 2'b00;

    repeat (4) @(negedge clk);
    check("a_scoreboard_drain", DW'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
